// File: rtl/frame_draw_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared types and defaults for the per-frame framebuffer write scheduler.
//   state_e      : sequencer states (IDLE, CLEAR, ARB, SERVE, FINISH)
//   SCREEN_W_DEF : default horizontal sweep limit (last cleared x)
//   SCREEN_H_DEF : default vertical sweep limit (last cleared y)
//   CW_DEF       : coordinate width
//   pixel_t      : one framebuffer write {x, y, color}
// -----------------------------------------------------------------------------
package draw_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int CW_DEF       = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ARB    = 3'd2,
        ST_SERVE  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    typedef struct packed {
        logic [CW_DEF-1:0] x;
        logic [CW_DEF-1:0] y;
        logic              color;
    } pixel_t;

endpackage

// File: rtl/frame_draw_scheduler_if.sv
// -----------------------------------------------------------------------------
// frame_draw_scheduler_if
// Bundles every non-clock/reset signal of the scheduler.
//   master : the scheduler (drives clr_start, grant, write bus, status)
//   slave  : the environment (frame tick, clear engine, sprite drawers,
//            framebuffer)
// -----------------------------------------------------------------------------
interface frame_draw_scheduler_if
    import draw_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int CW    = CW_DEF
);

    logic                  frame_tick;
    logic                  clr_start;
    logic [CW-1:0]         clr_x;
    logic [CW-1:0]         clr_y;
    logic                  clr_color;
    logic [N_REQ-1:0]      req;
    logic [N_REQ*CW-1:0]   src_x;
    logic [N_REQ*CW-1:0]   src_y;
    logic [N_REQ-1:0]      src_color;
    logic [N_REQ-1:0]      src_valid;
    logic [N_REQ-1:0]      src_done;
    logic [N_REQ-1:0]      grant;
    logic                  wr_en;
    logic [CW-1:0]         wr_x;
    logic [CW-1:0]         wr_y;
    logic                  wr_color;
    logic                  busy;
    logic                  frame_done;
    logic                  overrun;

    modport master (
        input  frame_tick, clr_x, clr_y, clr_color,
        input  req, src_x, src_y, src_color, src_valid, src_done,
        output clr_start, grant, wr_en, wr_x, wr_y, wr_color,
        output busy, frame_done, overrun
    );

    modport slave (
        output frame_tick, clr_x, clr_y, clr_color,
        output req, src_x, src_y, src_color, src_valid, src_done,
        input  clr_start, grant, wr_en, wr_x, wr_y, wr_color,
        input  busy, frame_done, overrun
    );

endinterface

// File: rtl/frame_draw_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.
//   cand   : candidate mask
//   ptr    : index the search starts from (wraps modulo N)
//   onehot : first candidate at or after ptr, one-hot (zero if none)
//   found  : at least one candidate exists
// -----------------------------------------------------------------------------
module rr_pick
    import draw_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  cand,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic          found
);

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        // Walk N positions starting at ptr; the first hit wins.
        for (int k = 0; k < N; k++) begin
            if (!found && cand[(int'(ptr) + k) % N]) begin
                onehot[(int'(ptr) + k) % N] = 1'b1;
                found                       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_draw_scheduler.sv
// -----------------------------------------------------------------------------
// frame_draw_scheduler
// Per-frame sequencer for the shared framebuffer write port. Each frame tick
// runs the clear sweep to (SCREEN_W, SCREEN_H), then hands the write port to
// each requesting sprite drawer once, in round-robin order, and finally pulses
// frame_done. The active source is muxed onto a registered write bus.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : frame_draw_scheduler_if.master (tick, clear engine, drawers,
//           grant, write bus, busy/frame_done/overrun)
// Note: the write register uses draw_pkg::pixel_t, so CW is expected to match
// draw_pkg::CW_DEF.
// -----------------------------------------------------------------------------
module frame_draw_scheduler
    import draw_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int N_REQ    = 3,
    parameter int CW       = CW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    frame_draw_scheduler_if.master bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] CLEAR  = ST_CLEAR;
    localparam logic [2:0] ARB    = ST_ARB;
    localparam logic [2:0] SERVE  = ST_SERVE;
    localparam logic [2:0] FINISH = ST_FINISH;

    logic [2:0]       state_q, state_d;
    logic             clr_start_q, clr_start_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             wr_en_q, wr_en_d;
    pixel_t           pix_q, pix_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] served_q, served_d;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] pick_onehot;
    logic             pick_found;
    logic [PW-1:0]    g_idx;
    logic             clr_last;

    // Per-drawer views of the packed coordinate buses.
    logic [CW-1:0] sx [N_REQ];
    logic [CW-1:0] sy [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign sx[gi] = bus.src_x[gi*CW +: CW];
            assign sy[gi] = bus.src_y[gi*CW +: CW];
        end
    endgenerate

    // Drawers already served this frame are masked until the next tick.
    assign cand = bus.req & ~served_q;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .cand   (cand),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .found  (pick_found)
    );

    // Index of the currently granted drawer (grant_q is one-hot in SERVE).
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx = PW'(i);
            end
        end
    end

    assign clr_last = (bus.clr_x == CW'(SCREEN_W)) && (bus.clr_y == CW'(SCREEN_H));

    always_comb begin
        state_d      = state_q;
        clr_start_d  = 1'b0;
        grant_d      = '0;
        wr_en_d      = 1'b0;
        pix_d        = pix_q;
        frame_done_d = 1'b0;
        // Any tick outside IDLE (FINISH included) is dropped and flagged.
        overrun_d    = bus.frame_tick && (state_q != IDLE);
        ptr_d        = ptr_q;
        served_d     = served_q;

        case (state_q)
            IDLE: begin
                if (bus.frame_tick) begin
                    state_d     = CLEAR;
                    clr_start_d = 1'b1;
                    served_d    = '0;
                end
            end

            CLEAR: begin
                wr_en_d = 1'b1;
                pix_d   = '{x: CW_DEF'(bus.clr_x), y: CW_DEF'(bus.clr_y),
                            color: bus.clr_color};
                // The corner pixel is written on the same edge we leave.
                if (clr_last) begin
                    state_d = ARB;
                end else begin
                    clr_start_d = 1'b1;
                end
            end

            ARB: begin
                if (pick_found) begin
                    grant_d = pick_onehot;
                    state_d = SERVE;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = FINISH;
                end
            end

            SERVE: begin
                wr_en_d = bus.src_valid[g_idx];
                pix_d   = '{x: CW_DEF'(sx[g_idx]), y: CW_DEF'(sy[g_idx]),
                            color: bus.src_color[g_idx]};
                // A drawer withdrawing its request is retired like a done.
                if (bus.src_done[g_idx] || !bus.req[g_idx]) begin
                    served_d[g_idx] = 1'b1;
                    ptr_d           = (int'(g_idx) == N_REQ - 1) ? '0 : g_idx + 1'b1;
                    state_d         = ARB;
                end else begin
                    grant_d = grant_q;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            clr_start_q  <= 1'b0;
            grant_q      <= '0;
            wr_en_q      <= 1'b0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            ptr_q        <= '0;
            served_q     <= '0;
        end else begin
            state_q      <= state_d;
            clr_start_q  <= clr_start_d;
            grant_q      <= grant_d;
            wr_en_q      <= wr_en_d;
            pix_q        <= pix_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            ptr_q        <= ptr_d;
            served_q     <= served_d;
        end
    end

    assign bus.clr_start  = clr_start_q;
    assign bus.grant      = grant_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_x       = CW'(pix_q.x);
    assign bus.wr_y       = CW'(pix_q.y);
    assign bus.wr_color   = pix_q.color;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_draw_scheduler
// Directed bench for frame_draw_scheduler using a small 8x4 clear sweep
// (SCREEN_W = 7, SCREEN_H = 3), a clear-engine model and three drawer models.
// Drawer i emits npix[i] pixels at (16*(i+1)+k, i+1), color 1, then done.
// -----------------------------------------------------------------------------
module tb_frame_draw_scheduler;
    import draw_pkg::*;

    localparam int W    = 7;
    localparam int H    = 3;
    localparam int N    = 3;
    localparam int CW   = 11;
    localparam int NCLR = (W + 1) * (H + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_draw_scheduler_if #(.N_REQ(N), .CW(CW)) bus ();

    frame_draw_scheduler #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .N_REQ    (N),
        .CW       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clear engine model ----------------
    logic [CW-1:0] cx, cy;
    always @(posedge clk) begin
        if (!bus.clr_start) begin
            cx <= '0;
            cy <= '0;
        end else if (cx == CW'(W)) begin
            cx <= '0;
            cy <= (cy == CW'(H)) ? '0 : cy + 1'b1;
        end else begin
            cx <= cx + 1'b1;
        end
    end
    assign bus.clr_x     = cx;
    assign bus.clr_y     = cy;
    assign bus.clr_color = 1'b0;

    // ---------------- drawer models ----------------
    int            npix [N];
    int            rem  [N];
    logic [N-1:0]  dv, dd;
    logic [CW-1:0] dx [N];
    logic [CW-1:0] dy [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!bus.grant[i]) begin
                rem[i] <= npix[i];
                dv[i]  <= 1'b0;
                dd[i]  <= 1'b0;
            end else if (rem[i] != 0) begin
                dv[i]  <= 1'b1;
                dd[i]  <= (rem[i] == 1);
                dx[i]  <= CW'(16 * (i + 1) + npix[i] - rem[i]);
                dy[i]  <= CW'(i + 1);
                rem[i] <= rem[i] - 1;
            end else begin
                dv[i] <= 1'b0;
                dd[i] <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign bus.src_x[gi*CW +: CW] = dx[gi];
            assign bus.src_y[gi*CW +: CW] = dy[gi];
        end
    endgenerate
    assign bus.src_valid = dv;
    assign bus.src_done  = dd;
    assign bus.src_color = '1;

    // ---------------- monitor ----------------
    typedef struct packed {
        int x;
        int y;
        int c;
    } wr_t;

    wr_t          wq [$];
    int           gq [$];
    int           fd_cnt     = 0;
    int           ov_cnt     = 0;
    int           onehot_bad = 0;
    logic [N-1:0] gprev      = '0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1)
            wq.push_back('{int'(bus.wr_x), int'(bus.wr_y), int'(bus.wr_color)});
        if (bus.grant != '0 && gprev == '0) begin
            for (int i = 0; i < N; i++)
                if (bus.grant[i]) gq.push_back(i);
        end
        if ($countones(bus.grant) > 1) onehot_bad <= onehot_bad + 1;
        if (bus.frame_done === 1'b1)   fd_cnt     <= fd_cnt + 1;
        if (bus.overrun === 1'b1)      ov_cnt     <= ov_cnt + 1;
        gprev <= bus.grant;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int s_w, s_g, s_fd, s_ov;

    task automatic tick();
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
    endtask

    task automatic start_frame(input string tag);
        s_w  = wq.size();
        s_g  = gq.size();
        s_fd = fd_cnt;
        s_ov = ov_cnt;
        tick();
        check({tag, ".clr_start"}, 32'(bus.clr_start), 1);
        check({tag, ".busy"}, 32'(bus.busy), 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy !== 1'b0 && n < budget);
        check({tag, ".idle"}, 32'(bus.busy), 0);
    endtask

    task automatic wait_grant(input string tag, input logic [N-1:0] mask, input int budget);
        int n;
        n = 0;
        while (bus.grant !== mask && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".grant_wait"}, 32'(bus.grant), 32'(mask));
    endtask

    task automatic finish_frame(input string tag, input int n, input int e0, input int e1,
                                input int e2, input int exp_ov);
        int  ord [3];
        int  exp_w, gv, bad, p;
        wr_t e;
        ord = '{e0, e1, e2};
        wait_idle(tag, 400);
        check({tag, ".frame_done"}, 32'(fd_cnt - s_fd), 1);
        check({tag, ".overrun"}, 32'(ov_cnt - s_ov), 32'(exp_ov));
        check({tag, ".ngrant"}, 32'(gq.size() - s_g), 32'(n));
        exp_w = NCLR;
        for (int k = 0; k < n; k++) begin
            gv = (s_g + k < gq.size()) ? gq[s_g + k] : -1;
            check($sformatf("%s.grant%0d", tag, k), 32'(gv), 32'(ord[k]));
            exp_w += npix[ord[k]];
        end
        check({tag, ".nwrites"}, 32'(wq.size() - s_w), 32'(exp_w));
        // Clear sweep must be raster order (x fastest), color 0.
        bad = 0;
        for (int j = 0; j < NCLR; j++) begin
            e = '{j % (W + 1), j / (W + 1), 0};
            if (s_w + j >= wq.size() || wq[s_w + j] != e) bad++;
        end
        check({tag, ".clear_seq"}, 32'(bad), 0);
        // Drawer pixels follow in grant order.
        bad = 0;
        p   = s_w + NCLR;
        for (int k = 0; k < n; k++) begin
            for (int m = 0; m < npix[ord[k]]; m++) begin
                e = '{16 * (ord[k] + 1) + m, ord[k] + 1, 1};
                if (p >= wq.size() || wq[p] != e) bad++;
                p++;
            end
        end
        check({tag, ".draw_seq"}, 32'(bad), 0);
        check({tag, ".clr_start_low"}, 32'(bus.clr_start), 0);
        $display("frame %s: %0d writes, %0d grants, %0d overruns", tag,
                 wq.size() - s_w, gq.size() - s_g, ov_cnt - s_ov);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.frame_tick = 1'b0;
        bus.req        = '0;
        npix           = '{4, 4, 4};

        repeat (3) @(negedge clk);
        check("rst.grant", 32'(bus.grant), 0);
        check("rst.wr_en", 32'(bus.wr_en), 0);
        check("rst.clr_start", 32'(bus.clr_start), 0);
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.frame_done", 32'(bus.frame_done), 0);
        check("rst.overrun", 32'(bus.overrun), 0);
        @(negedge clk) reset = 1'b0;

        // Clear-only frame.
        start_frame("clr");
        finish_frame("clr", 0, 0, 0, 0, 0);

        // Round robin from pointer 0, then move pointer to 1.
        bus.req = 3'b111;
        start_frame("rr1");
        finish_frame("rr1", 3, 0, 1, 2, 0);
        bus.req = 3'b001;
        start_frame("ptr");
        finish_frame("ptr", 1, 0, 0, 0, 0);
        bus.req = 3'b111;
        start_frame("rr2");
        finish_frame("rr2", 3, 1, 2, 0, 0);

        // Drawer 2 re-requests after being served: waits for next frame.
        start_frame("late");
        wait_grant("late", 3'b001, 400);
        bus.req[2] = 1'b0;
        @(negedge clk) bus.req[2] = 1'b1;
        finish_frame("late", 3, 1, 2, 0, 0);
        start_frame("late2");
        finish_frame("late2", 3, 1, 2, 0, 0);

        // Tick while serving drawer 1.
        start_frame("ovr");
        wait_grant("ovr", 3'b010, 400);
        tick();
        check("ovr.pulse", 32'(bus.overrun), 1);
        @(negedge clk);
        check("ovr.one_cycle", 32'(bus.overrun), 0);
        finish_frame("ovr", 3, 1, 2, 0, 1);

        // Asynchronous reset while drawer 1 is writing.
        start_frame("rst");
        wait_grant("rst", 3'b010, 400);
        n = 0;
        while (bus.wr_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst.mid_write", 32'(bus.wr_en), 1);
        #2 reset = 1'b1;
        #1;
        check("rst.async_grant", 32'(bus.grant), 0);
        check("rst.async_wr_en", 32'(bus.wr_en), 0);
        check("rst.async_clr_start", 32'(bus.clr_start), 0);
        check("rst.async_busy", 32'(bus.busy), 0);
        @(negedge clk) reset = 1'b0;
        start_frame("post");
        finish_frame("post", 3, 0, 1, 2, 0);

        // Drawer 1 never draws and withdraws its request.
        npix[1] = 0;
        start_frame("drop");
        wait_grant("drop", 3'b010, 400);
        repeat (2) @(negedge clk);
        bus.req[1] = 1'b0;
        @(negedge clk);
        check("drop.arb_grant", 32'(bus.grant), 0);
        check("drop.arb_wr_en", 32'(bus.wr_en), 0);
        check("drop.arb_busy", 32'(bus.busy), 1);
        @(negedge clk);
        check("drop.next_grant", 32'(bus.grant), 32'(3'b100));
        finish_frame("drop", 3, 0, 1, 2, 0);
        bus.req[1] = 1'b1;

        check("onehot", 32'(onehot_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
